id_inst_buffer: RTL and testbench

Parametrised instruction buffer between IF and ID. It replaces the single IF→ID pipeline register with a DEPTH-entry FIFO of {pc, inst} pairs, so fetch keeps running while decode is stalled. Held stall cycles present a zero bubble to decode rather than a stale instruction. A branch flush that preserves the MIPS delay slot is built in. The block sits directly in front of the decoder and its register-file read logic.

---
 rtl/id_inst_buffer.sv | 111 +++++++++++
 tb/tb_id_inst_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/id_inst_buffer.sv
// IF->ID instruction buffer: DEPTH-entry FIFO of {pc, inst} with a bubble-masked head and a delay-slot-aware flush.
// Optional same-cycle bypass into an empty buffer is enabled by defining ID_BUF_BYPASS_EN.
module id_inst_buffer #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PC_W-1:0]              in_pc,
  input  logic [INST_W-1:0]            in_inst,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output logic [INST_W-1:0]            out_inst,
  input  logic                         flush,
  input  logic                         flush_ds,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PW-1:0]     wp, rp, wp_nxt, rp_nxt;
  logic [CW-1:0]     count_nxt;
  logic              empty, bypass, wr_en, push, pop;

  assign empty    = (count == '0);
  assign in_ready = (count != FULL);

`ifdef ID_BUF_BYPASS_EN
  // An empty buffer forwards IF straight to decode; suppressed while flushing.
  assign bypass = empty & in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = ~empty | bypass;

  always_comb begin
    out_pc   = '0;
    out_inst = '0;
    if (!empty) begin
      out_pc   = pc_mem[rp];
      out_inst = inst_mem[rp];
    end else if (bypass) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end
  end

  always_comb begin
    wr_en     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    wp_nxt    = wp;
    rp_nxt    = rp;
    count_nxt = count;
    if (flush) begin
      if (!flush_ds) begin
        count_nxt = '0;
        rp_nxt    = wp;
      end else if (!empty) begin
        // Head is the delay slot: keep only it, ignore any pop of it.
        count_nxt = CW'(1);
        wp_nxt    = rp + PW'(1);
      end else if (in_valid) begin
        wr_en     = 1'b1;
        wp_nxt    = wp + PW'(1);
        count_nxt = CW'(1);
      end
    end else begin
      push  = in_valid & in_ready & ~(bypass & out_ready);
      pop   = ~empty & out_ready;
      wr_en = push;
      if (push) wp_nxt = wp + PW'(1);
      if (pop)  rp_nxt = rp + PW'(1);
      case ({push, pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp_nxt;
      rp    <= rp_nxt;
      count <= count_nxt;
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wp]   <= in_pc;
      inst_mem[wp] <= in_inst;
    end
  end

endmodule

// File: tb/tb_id_inst_buffer.sv
// Bench for id_inst_buffer: directed steps then random traffic against a queue-based reference model.
module tb_id_inst_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, flush, flush_ds;
  logic [31:0]   in_pc, in_inst, out_pc, out_inst;
  logic [CW-1:0] count;

  id_inst_buffer #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .flush(flush), .flush_ds(flush_ds), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t q[$];
  int errors = 0;
  int checks = 0;

`ifdef ID_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic bit m_bypass();
    return BYP && q.size() == 0 && in_valid && !flush;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    logic [31:0] e_pc, e_inst;
    bit e_vld;
    #1;
    e_vld  = (q.size() != 0) || m_bypass();
    e_pc   = 32'h0;
    e_inst = 32'h0;
    if (q.size() != 0) begin
      e_pc = q[0].pc; e_inst = q[0].inst;
    end else if (m_bypass()) begin
      e_pc = in_pc; e_inst = in_inst;
    end
    chk({tag, ".count"},     32'(count),     32'(q.size()));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() != DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_vld));
    chk({tag, ".out_pc"},    out_pc,   e_pc);
    chk({tag, ".out_inst"},  out_inst, e_inst);
  endtask

  // Reference update from the rules: FIFO semantics, flush keeps or drops the head.
  task automatic tick();
    ent_t e;
    bit pop, push, byp;
    e.pc = in_pc; e.inst = in_inst;
    if (flush) begin
      if (!flush_ds) q.delete();
      else if (q.size() > 0) begin
        while (q.size() > 1) void'(q.pop_back());
      end else if (in_valid) q.push_back(e);
    end else begin
      byp  = m_bypass();
      pop  = q.size() > 0 && out_ready;
      push = in_valid && q.size() != DEPTH && !(byp && out_ready);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit ordy, input bit fl, input bit fds);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = pc ^ 32'h5A5A_0000;
    out_ready = ordy;
    flush     = fl;
    flush_ds  = fds;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 32'h0, 0, 0, 0);
    #3 rst = 1'b0;
    check_outs("reset");

    // Single push then pop
    @(posedge clk); #1;
    drive(1, 32'hBFC0_0000, 0, 0, 0);
    in_inst = 32'h3C01_1234;
    check_outs("single_push_pre");
    tick();
    drive(0, 32'h0, 0, 0, 0);
    check_outs("single_push");
    chk("single_inst", out_inst, 32'h3C01_1234);
    drive(0, 32'h0, 1, 0, 0);
    tick();
    drive(0, 32'h0, 0, 0, 0);
    check_outs("single_pop");

    // Overfill with decode stalled, then pop with push offered while full
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h1000 + 32'(i) * 4, 0, 0, 0);
      check_outs("fill");
      tick();
    end
    chk("full_count", 32'(count), 32'd4);
    drive(1, 32'h1010, 1, 0, 0);
    check_outs("full_pop_push");
    tick();
    drive(0, 32'h0, 0, 0, 0);
    check_outs("after_full_pop");
    chk("after_full_count", 32'(count), 32'd3);
    drive(0, 32'h0, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    drive(0, 32'h0, 0, 0, 0);
    check_outs("drained");

    // Flush with delay slot on occupied buffer, then plain flush
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100 + 32'(i) * 4, 0, 0, 0);
      tick();
    end
    drive(1, 32'h10C, 1, 1, 1);
    tick();
    drive(0, 32'h0, 0, 0, 0);
    check_outs("flush_ds_kept");
    chk("flush_ds_head", out_pc, 32'h100);
    drive(1, 32'h110, 1, 1, 0);
    tick();
    drive(0, 32'h0, 0, 0, 0);
    check_outs("flush_plain");

    // Flush with delay slot on empty buffer writes the incoming slot
    drive(1, 32'h200, 0, 1, 1);
    tick();
    drive(0, 32'h0, 0, 0, 0);
    check_outs("flush_ds_empty");
    chk("flush_ds_empty_pc", out_pc, 32'h200);
    drive(0, 32'h0, 1, 0, 0);
    tick();

    // Streaming push/pop, wraps the pointers several times
    drive(1, 32'h0, 0, 0, 0);
    tick();
    for (int i = 1; i < 20; i++) begin
      drive(1, 32'(i) * 4, 1, 0, 0);
      check_outs("stream");
      tick();
    end
    drive(0, 32'h0, 0, 0, 0);
    check_outs("stream_end");
    chk("stream_last", out_pc, 32'h4C);

    // Async reset mid-fill
    drive(0, 32'h0, 1, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(i) * 4, 0, 0, 0);
      tick();
    end
    drive(0, 32'h0, 0, 0, 0);
    #1;
    chk("prereset_count", 32'(count), 32'd3);
    rst = 1'b1;
    q.delete();
    check_outs("async_reset");
    rst = 1'b0;

    // Empty push with decode ready (same-cycle consume when bypass is built in)
    drive(1, 32'h400, 1, 0, 0);
    check_outs("bypass_cycle");
    tick();
    drive(0, 32'h0, 0, 0, 0);
    check_outs("bypass_after");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
      in_inst = $urandom;
      check_outs("rand");
      tick();
    end
    drive(0, 32'h0, 0, 0, 0);
    check_outs("rand_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
